// File: rtl/spi_reg_pkg.sv
// Shared constants for the SPI-slave to register-bus bridge.
// Frame layout: 16-bit command (W bit, 3 ignored bits, 12-bit address),
// then 32 write-data bits, or 8 dummy bits followed by 32 read-data bits.
package spi_reg_pkg;

  localparam int unsigned ADDR_W_DEF    = 12;
  localparam int unsigned DATA_W_DEF    = 32;
  localparam int unsigned CMD_BITS      = 16;
  localparam int unsigned DUMMY_BITS    = 8;
  localparam int unsigned WR_FRAME_BITS = CMD_BITS + DATA_W_DEF;
  localparam int unsigned RD_DATA_START = CMD_BITS + DUMMY_BITS;
  localparam int unsigned W_BIT         = 15;
  localparam int unsigned CNT_W         = 6;
  localparam int unsigned CNT_MAX       = 63;

endpackage

// File: rtl/spi_reg_sync.sv
// Two-flop synchroniser plus history flop with edge detection.
// Ports: clk/reset (sync, active-high), d_i async input,
//        level_o synchronised level, rise_c_o/fall_c_o single-cycle edges.
module spi_reg_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic level_o,
  output logic rise_c_o,
  output logic fall_c_o
);

  logic meta_q, sync_q, hist_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      hist_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      hist_q <= sync_q;
    end
  end

  assign level_o  = sync_q;
  assign rise_c_o = sync_q & ~hist_q;
  assign fall_c_o = ~sync_q & hist_q;

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI-slave (mode 0) to single-cycle register strobe bridge, all in clk domain.
// Ports: clk/reset (sync, active-high); spi_clk/spi_ncs/spi_di async SPI inputs;
//        spi_do MISO; r_valid/r_wen/r_addr/r_wdata register strobe; r_rdata
//        combinational read data sampled during a read strobe.
module spi_reg_bridge
  import spi_reg_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_clk,
  input  logic              spi_ncs,
  input  logic              spi_di,
  output logic              spi_do,
  output logic              r_valid,
  output logic              r_wen,
  output logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_wdata,
  input  logic [DATA_W-1:0] r_rdata
);

  localparam int unsigned SR_W = CMD_BITS + DATA_W;

  logic sclk_rise, sclk_fall, ncs_s, di_s;
  logic sclk_level_unused, ncs_rise_unused, ncs_fall_unused;
  logic di_rise_unused, di_fall_unused;

  spi_reg_sync #(.RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .d_i(spi_clk),
    .level_o(sclk_level_unused), .rise_c_o(sclk_rise), .fall_c_o(sclk_fall)
  );

  spi_reg_sync #(.RESET_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .reset(reset), .d_i(spi_ncs),
    .level_o(ncs_s), .rise_c_o(ncs_rise_unused), .fall_c_o(ncs_fall_unused)
  );

  spi_reg_sync #(.RESET_VAL(1'b0)) u_sync_di (
    .clk(clk), .reset(reset), .d_i(spi_di),
    .level_o(di_s), .rise_c_o(di_rise_unused), .fall_c_o(di_fall_unused)
  );

  logic [1:0]        settle_q, settle_d;
  logic              armed_q, armed_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SR_W-2:0]   sr_in_q, sr_in_d;
  logic [SR_W-1:0]   sr_next;
  logic [DATA_W-1:0] sr_out_q, sr_out_d;
  logic              issued_q, issued_d;
  logic              rd_frame_q, rd_frame_d;
  logic              spi_do_q, spi_do_d;
  logic              r_valid_q, r_valid_d;
  logic              r_wen_q, r_wen_d;
  logic [ADDR_W-1:0] r_addr_q, r_addr_d;
  logic [DATA_W-1:0] r_wdata_q, r_wdata_d;

  // Frame decode, strobe generation and MISO shifting.
  always_comb begin
    settle_d   = {settle_q[0], 1'b1};
    armed_d    = armed_q;
    cnt_d      = cnt_q;
    sr_in_d    = sr_in_q;
    sr_out_d   = sr_out_q;
    issued_d   = issued_q;
    rd_frame_d = rd_frame_q;
    spi_do_d   = spi_do_q;
    r_valid_d  = 1'b0;
    r_wen_d    = r_wen_q;
    r_addr_d   = r_addr_q;
    r_wdata_d  = r_wdata_q;
    sr_next    = {sr_in_q, di_s};

    // Accept frames only once a settled, high ncs has been seen after reset.
    if (settle_q[1] && ncs_s) armed_d = 1'b1;

    if (ncs_s) begin
      cnt_d      = '0;
      sr_in_d    = '0;
      sr_out_d   = '0;
      issued_d   = 1'b0;
      rd_frame_d = 1'b0;
      spi_do_d   = 1'b0;
    end else if (armed_q) begin
      if (sclk_rise) begin
        sr_in_d = sr_next[SR_W-2:0];
        if (cnt_q != CNT_W'(CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
        // Read: the command has just completed with W=0.
        if (!issued_q && cnt_q == CNT_W'(CMD_BITS - 1) && !sr_next[W_BIT]) begin
          r_valid_d  = 1'b1;
          r_wen_d    = 1'b0;
          r_addr_d   = sr_next[ADDR_W-1:0];
          issued_d   = 1'b1;
          rd_frame_d = 1'b1;
        end
        // Write: command sits in the top 16 bits, data in the low DATA_W.
        if (!issued_q && cnt_q == CNT_W'(SR_W - 1) && sr_next[DATA_W + W_BIT]) begin
          r_valid_d = 1'b1;
          r_wen_d   = 1'b1;
          r_addr_d  = sr_next[DATA_W +: ADDR_W];
          r_wdata_d = sr_next[DATA_W-1:0];
          issued_d  = 1'b1;
        end
      end
      if (sclk_fall && rd_frame_q && cnt_q >= CNT_W'(RD_DATA_START)) begin
        spi_do_d = sr_out_q[DATA_W-1];
        sr_out_d = {sr_out_q[DATA_W-2:0], 1'b0};
      end
      // r_rdata is valid while the read strobe is on the bus.
      if (r_valid_q && !r_wen_q) sr_out_d = r_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      settle_q   <= '0;
      armed_q    <= 1'b0;
      cnt_q      <= '0;
      sr_in_q    <= '0;
      sr_out_q   <= '0;
      issued_q   <= 1'b0;
      rd_frame_q <= 1'b0;
      spi_do_q   <= 1'b0;
      r_valid_q  <= 1'b0;
      r_wen_q    <= 1'b0;
      r_addr_q   <= '0;
      r_wdata_q  <= '0;
    end else begin
      settle_q   <= settle_d;
      armed_q    <= armed_d;
      cnt_q      <= cnt_d;
      sr_in_q    <= sr_in_d;
      sr_out_q   <= sr_out_d;
      issued_q   <= issued_d;
      rd_frame_q <= rd_frame_d;
      spi_do_q   <= spi_do_d;
      r_valid_q  <= r_valid_d;
      r_wen_q    <= r_wen_d;
      r_addr_q   <= r_addr_d;
      r_wdata_q  <= r_wdata_d;
    end
  end

  assign spi_do  = spi_do_q;
  assign r_valid = r_valid_q;
  assign r_wen   = r_wen_q;
  assign r_addr  = r_addr_q;
  assign r_wdata = r_wdata_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Self-checking bench for spi_reg_bridge: SPI master driven at clk/10, strobes
// captured by a monitor and compared against a frame-level reference model.
module tb_spi_reg_bridge;

  typedef struct packed {
    logic        wen;
    logic [11:0] addr;
    logic [31:0] wdata;
  } strobe_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        spi_clk = 1'b0;
  logic        spi_ncs = 1'b1;
  logic        spi_di = 1'b0;
  logic        spi_do;
  logic        r_valid;
  logic        r_wen;
  logic [11:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;

  int errors = 0;
  int checks = 0;

  strobe_t got_q[$];
  strobe_t exp_q[$];
  logic [11:0] last_addr = '0;
  logic [31:0] last_wdata = '0;

  always #5 clk = ~clk;

  spi_reg_bridge dut (
    .clk(clk), .reset(reset), .spi_clk(spi_clk), .spi_ncs(spi_ncs),
    .spi_di(spi_di), .spi_do(spi_do), .r_valid(r_valid), .r_wen(r_wen),
    .r_addr(r_addr), .r_wdata(r_wdata), .r_rdata(r_rdata)
  );

  // Register file stand-in: address 0x800 reads 0x00800001.
  function automatic logic [31:0] rdata_of(input logic [11:0] a);
    logic [31:0] a32;
    a32 = 32'(a);
    return ((a32 << 12) | 32'h1) ^ (a32 << 24);
  endfunction

  assign r_rdata = rdata_of(r_addr);

  // Every cycle with r_valid high is one captured strobe.
  always @(negedge clk) begin
    if (!reset && r_valid === 1'b1) got_q.push_back({r_wen, r_addr, r_wdata});
  end

  // Frame-level model: what a master should see for a frame of n bits.
  task automatic model_frame(input logic [63:0] bits, input int n, output logic [63:0] exp_miso);
    logic [15:0] cmd;
    logic [31:0] rd;
    cmd = bits[63:48];
    exp_miso = '0;
    if (n >= 16) begin
      if (cmd[15]) begin
        if (n >= 48) begin
          last_addr  = cmd[11:0];
          last_wdata = bits[47:16];
          exp_q.push_back({1'b1, last_addr, last_wdata});
        end
      end else begin
        last_addr = cmd[11:0];
        rd = rdata_of(last_addr);
        exp_q.push_back({1'b0, last_addr, last_wdata});
        for (int i = 24; i < n && i < 56; i++) exp_miso[63-i] = rd[31-(i-24)];
      end
    end
  endtask

  // Mode 0 bits, MSB of 'bits' first; MISO sampled at each rising edge.
  task automatic send_bits(input logic [63:0] bits, input int n, output logic [63:0] miso);
    miso = '0;
    for (int i = 0; i < n; i++) begin
      spi_di = bits[63-i];
      #50;
      spi_clk = 1'b1;
      miso[63-i] = spi_do;
      #50;
      spi_clk = 1'b0;
    end
    spi_di = 1'b0;
  endtask

  task automatic do_frame(input logic [63:0] bits, input int n, input int gap,
                          output logic [63:0] miso, output logic [63:0] exp_miso);
    model_frame(bits, n, exp_miso);
    spi_ncs = 1'b0;
    #50;
    send_bits(bits, n, miso);
    #50;
    spi_ncs = 1'b1;
    repeat (gap) @(posedge clk);
  endtask

  task automatic test_reset();
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({r_valid, r_wen, r_addr, r_wdata, spi_do} !== 47'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b w=%b a=%h d=%h do=%b required all 0",
               r_valid, r_wen, r_addr, r_wdata, spi_do);
    end
    @(negedge clk) reset = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  task automatic test_write();
    logic [63:0] m, em;
    got_q.delete(); exp_q.delete();
    do_frame({16'h8123, 32'hDEADBEEF, 16'h0}, 48, 8, m, em);
    checks++;
    if (got_q.size() !== 1) begin
      errors++; $display("FAIL write_count: got %0d required 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== exp_q[0]) begin
        errors++; $display("FAIL write_strobe: got %h required %h", got_q[0], exp_q[0]);
      end
    end
    checks++;
    if (m !== em) begin
      errors++; $display("FAIL write_miso: got %h required %h", m, em);
    end
  endtask

  task automatic test_read();
    logic [63:0] m, em;
    logic [31:0] data_bits;
    got_q.delete(); exp_q.delete();
    do_frame({16'h0800, 8'h00, 32'hA5A5_0F0F, 8'h0}, 56, 8, m, em);
    checks++;
    if (got_q.size() !== 1) begin
      errors++; $display("FAIL read_count: got %0d required 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== exp_q[0]) begin
        errors++; $display("FAIL read_strobe: got %h required %h", got_q[0], exp_q[0]);
      end
    end
    data_bits = m[39:8];
    checks++;
    if (data_bits !== 32'h0080_0001) begin
      errors++; $display("FAIL read_data: got %h required 00800001", data_bits);
    end
    checks++;
    if (m !== em) begin
      errors++; $display("FAIL read_miso: got %h required %h", m, em);
    end
  endtask

  task automatic test_abort();
    logic [63:0] m, em;
    got_q.delete(); exp_q.delete();
    do_frame({16'h8010, 20'hABCDE, 28'h0}, 36, 8, m, em);
    checks++;
    if (got_q.size() !== 0) begin
      errors++; $display("FAIL abort_count: got %0d required 0", got_q.size());
    end
    do_frame({16'h8010, 32'h0000_0055, 16'h0}, 48, 8, m, em);
    checks++;
    if (got_q.size() !== 1) begin
      errors++; $display("FAIL abort_next_count: got %0d required 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== exp_q[0]) begin
        errors++; $display("FAIL abort_next_strobe: got %h required %h", got_q[0], exp_q[0]);
      end
    end
  endtask

  task automatic test_overlong();
    logic [63:0] m, em;
    got_q.delete(); exp_q.delete();
    do_frame({16'h8ABC, 32'h1357_9BDF, 16'hFFFF}, 64, 8, m, em);
    checks++;
    if (got_q.size() !== 1) begin
      errors++; $display("FAIL overlong_count: got %0d required 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== exp_q[0]) begin
        errors++; $display("FAIL overlong_strobe: got %h required %h", got_q[0], exp_q[0]);
      end
    end
    checks++;
    if (m !== em) begin
      errors++; $display("FAIL overlong_miso: got %h required %h", m, em);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] m0, em0, m1, em1;
    got_q.delete(); exp_q.delete();
    do_frame({16'h3001, 8'h00, 32'h0, 8'h0}, 56, 4, m0, em0);
    do_frame({16'h8004, 32'h0000_00C1, 16'h0}, 48, 8, m1, em1);
    checks++;
    if (got_q.size() !== 2) begin
      errors++; $display("FAIL b2b_count: got %0d required 2", got_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL b2b_strobe%0d: got %h required %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (m0 !== em0 || m1 !== em1) begin
      errors++; $display("FAIL b2b_miso: got %h/%h required %h/%h", m0, m1, em0, em1);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] m, em;
    got_q.delete(); exp_q.delete();
    spi_ncs = 1'b0;
    #50;
    send_bits({16'h8ABC, 48'h0}, 10, m);
    @(negedge clk) reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ({r_valid, r_wen, r_addr, r_wdata, spi_do} !== 47'd0) begin
      errors++;
      $display("FAIL midreset_outputs: got v=%b w=%b a=%h d=%h do=%b required all 0",
               r_valid, r_wen, r_addr, r_wdata, spi_do);
    end
    @(negedge clk) reset = 1'b0;
    last_addr = '0;
    last_wdata = '0;
    // ncs never went high since reset: this whole frame must be ignored.
    send_bits({16'h8ABC, 32'h1234_5678, 16'h0}, 48, m);
    repeat (10) @(posedge clk);
    checks++;
    if (got_q.size() !== 0) begin
      errors++; $display("FAIL midreset_ignored: got %0d strobes required 0", got_q.size());
    end
    spi_ncs = 1'b1;
    repeat (6) @(posedge clk);
    do_frame({16'h8ABC, 32'h0F0F_1234, 16'h0}, 48, 8, m, em);
    checks++;
    if (got_q.size() !== 1) begin
      errors++; $display("FAIL midreset_next_count: got %0d required 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== exp_q[0]) begin
        errors++; $display("FAIL midreset_next_strobe: got %h required %h", got_q[0], exp_q[0]);
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] m, em;
    logic [63:0] bits;
    int n;
    for (int f = 0; f < 10; f++) begin
      got_q.delete(); exp_q.delete();
      bits = {$urandom(), $urandom()};
      n = (f % 3 == 0) ? 48 + 8 * (f % 2) : int'($urandom_range(12, 64));
      do_frame(bits, n, int'($urandom_range(4, 10)), m, em);
      checks++;
      if (got_q.size() !== exp_q.size()) begin
        errors++;
        $display("FAIL rand%0d_count: got %0d required %0d (cmd %h n %0d)",
                 f, got_q.size(), exp_q.size(), bits[63:48], n);
      end else if (exp_q.size() == 1) begin
        checks++;
        if (got_q[0] !== exp_q[0]) begin
          errors++; $display("FAIL rand%0d_strobe: got %h required %h", f, got_q[0], exp_q[0]);
        end
      end
      checks++;
      if (m !== em) begin
        errors++; $display("FAIL rand%0d_miso: got %h required %h (n %0d)", f, m, em, n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_overlong();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_reg_bridge.md
Name: spi_reg_bridge

Overview:
- SPI-slave to register-bus bridge: an external MCU (SPI master) issues 32-bit register reads and writes into the `clk` domain.
- SPI pins are asynchronous to `clk`. They are oversampled through synchronisers, and all logic runs on `clk`.
- Drives a simple single-cycle register strobe (`r_valid`/`r_wen`/`r_addr`/`r_wdata`). The SoC decodes this strobe and returns `r_rdata` combinationally.

Parameters:
- ADDR_W, 12, register word-address width.
- DATA_W, 32, register data width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- spi_clk  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous.
- spi_ncs  in  1  SPI chip select, active low, asynchronous.
- spi_di  in  1  SPI MOSI, MSB first.
- spi_do  out  1  SPI MISO, MSB first.
- r_valid  out  1  one-cycle transaction strobe.
- r_wen  out  1  1 = write, 0 = read; valid with r_valid.
- r_addr  out  ADDR_W  register word address.
- r_wdata  out  DATA_W  write data.
- r_rdata  in  DATA_W  read data; sampled in the cycle r_valid=1 && r_wen=0.

Behaviour:
- Synchronisation:
  - spi_clk, spi_ncs and spi_di each pass through a 2-flop synchroniser plus one history flop.
  - Rise and fall of spi_clk are detected from the synchronised samples.
  - Supported ratio: f(spi_clk) ≤ f(clk)/8.
- Frame structure: one transaction per spi_ncs low period.
  - Command: 16 bits, MSB first. Bit15 = W (1 = write). Bits14:12 ignored. Bits11:0 = address.
  - Write frame: command followed by 32 data bits; 48 bits total.
  - Read frame: command, then 8 dummy bits (input ignored), then 32 bits of read data on spi_do; 56 bits total.
- Bit sampling:
  - Input bits are shifted in on each detected spi_clk rising edge while synchronised ncs=0.
  - A 6-bit bit counter increments per bit and saturates at 63.
- Write timing:
  - On the rising edge of bit 48 of a write frame, on the following clk: r_valid=1, r_wen=1, r_addr=command address, r_wdata=the 32 data bits.
  - r_valid is high for exactly one cycle.
- Read timing:
  - On the rising edge of bit 16 with W=0, on the following clk: r_valid=1, r_wen=0, r_addr set.
  - In that same cycle, r_rdata is captured into the output shift register.
- spi_do:
  - Updated on each detected spi_clk falling edge; shifts out the output shift register MSB first.
  - Sequencing: the falling edge after bit 24 presents read-data bit 31; subsequent falling edges present bits 30..0.
  - spi_do=0 during the command, during the dummy bits, for write frames, and whenever ncs is high.
- Frame end:
  - Extra bits beyond the frame length are ignored; no further strobes are issued.
  - ncs rising (synchronised) resets the bit counter and shift registers to 0, and clears the write/read-issued flag.
  - ncs rising before a write frame completes aborts it with no strobe.
  - A read strobe already issued is not retracted if ncs rises.
- Reset values: r_valid=0, r_wen=0, r_addr=0, r_wdata=0, spi_do=0, bit counter=0. Synchroniser flops reset to idle (ncs=1, clk=0).
- Reset asserted mid-frame aborts the frame. After reset, the bridge waits for ncs high before accepting a new frame.
- r_addr, r_wen and r_wdata hold their last values between strobes.

Decomposition:
- Shared package spi_reg_pkg:
  - Constants: CMD_BITS=16, DUMMY_BITS=8, WR_FRAME_BITS=48, RD_DATA_START=24, W_BIT=15.
  - Default ADDR_W and DATA_W.
- One natural sub-module: spi_reg_sync, a 3-flop synchroniser plus edge detector, instanced per input (rise and fall outputs for spi_clk).

Test Plan:
- Write: ncs low; send 0x8123 then 0xDEADBEEF at clk/10 → exactly one r_valid pulse with r_wen=1, r_addr=0x123, r_wdata=0xDEADBEEF; spi_do stays 0.
- Read: send 0x0800, 8 dummy bits, clock 32 more bits with r_rdata tied to 0x800001 while r_addr==0x800 → r_valid pulse with r_wen=0, r_addr=0x800; MISO bits read 0x00800001.
- Abort: send 0x8010 plus 20 data bits, then raise ncs → no r_valid. A following full write of 0x8010/0x00000055 → one pulse with r_wdata=0x55.
- Overlong frame: write frame followed by 16 extra clocks before ncs high → exactly one r_valid.
- Back-to-back: read 0x3001, then write 0x8004 with 0x000000C1, with ncs high for 4 clk between frames → two strobes in order with correct fields.
- Reset mid-frame: assert reset after 10 bits → outputs return to 0 and no strobe. The next full frame after an ncs high period works normally.
